// File: rtl/imem_loader_if.sv
// Byte-serial program loader port between the host and imem_loader.
interface imem_loader_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       ld_restart;

  modport master (
    output ld_valid, ld_data, ld_last, ld_restart,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, ld_restart,
    output ld_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a byte-serial loader. Packs host bytes into
// little-endian 32-bit words, then releases the core from reset and serves
// instructions combinationally at pc.
// Optional macro IMEM_LOADER_CHECKSUM_EN: the ld_last byte becomes a mod-256
// checksum over all preceding bytes instead of program data.
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = 8,
  parameter logic [31:0] FILL_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [31:0]       pc,
  output logic [31:0]       inst,
  imem_loader_if.slave      ld,
  output logic              core_nrst,
  output logic              busy,
  output logic              err,
  output logic [AW:0]       words_loaded
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] waddr_q, waddr_d;
  logic [31:0]   asm_q, asm_d;
  logic          core_nrst_q, core_nrst_d;
  logic          ld_ready_q, ld_ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic [31:0]   mem [DEPTH];

  logic          accept_c;
  logic          full_c;
  logic [31:0]   merged_c;
  logic          write_req_c;
  logic [31:0]   write_word_c;
  logic          go_run_c;
  logic          mem_we_c;
  logic [31:0]   mem_wdata_c;
  logic [29:0]   widx_c;
  logic          fetch_ok_c;

  // Next-state, counter and memory-write decode
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    waddr_d      = waddr_q;
    asm_d        = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    write_req_c  = 1'b0;
    write_word_c = '0;
    go_run_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_wdata_c  = '0;

    accept_c = ld.ld_valid && ld_ready_q;
    full_c   = (waddr_q == CW'(DEPTH));
    merged_c = asm_q | (32'(ld.ld_data) << {lane_q, 3'b000});

    if (ld.ld_restart) begin
      // Restart is honoured in every state; a byte in the same cycle is dropped
      state_d = S_IDLE;
      lane_d  = '0;
      waddr_d = '0;
      asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else if ((state_q == S_IDLE || state_q == S_LOAD) && accept_c) begin
      state_d = S_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (ld.ld_last) begin
        // Checksum byte: flush any partial word, then verify the sum
        write_req_c  = (lane_q != 2'd0);
        write_word_c = asm_q;
        go_run_c     = (8'(sum_q + ld.ld_data) == 8'h00);
      end else begin
        sum_d        = 8'(sum_q + ld.ld_data);
        asm_d        = merged_c;
        lane_d       = lane_q + 2'd1;
        write_req_c  = (lane_q == 2'd3);
        write_word_c = merged_c;
      end
`else
      asm_d        = merged_c;
      lane_d       = lane_q + 2'd1;
      write_req_c  = (lane_q == 2'd3) || ld.ld_last;
      write_word_c = merged_c;
      go_run_c     = 1'b1;
`endif
      if (write_req_c) begin
        if (full_c) begin
          state_d = S_ERROR;
        end else begin
          mem_we_c    = 1'b1;
          mem_wdata_c = write_word_c;
          waddr_d     = waddr_q + CW'(1);
          asm_d       = '0;
        end
      end
      if (ld.ld_last && state_d != S_ERROR) begin
        state_d = go_run_c ? S_RUN : S_ERROR;
      end
    end

    core_nrst_d = (state_d == S_RUN);
    ld_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d      = (state_d == S_IDLE) || (state_d == S_LOAD);
    err_d       = (state_d == S_ERROR);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      waddr_q     <= '0;
      asm_q       <= '0;
      core_nrst_q <= 1'b0;
      ld_ready_q  <= 1'b1;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      waddr_q     <= waddr_d;
      asm_q       <= asm_d;
      core_nrst_q <= core_nrst_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Instruction storage; intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[waddr_q[AW-1:0]] <= mem_wdata_c;
    end
  end

  // Combinational fetch, only valid for aligned in-range pc while running
  always_comb begin
    widx_c     = pc[31:2];
    fetch_ok_c = (state_q == S_RUN) && (pc[1:0] == 2'b00) && (widx_c < 30'(DEPTH));
    inst       = fetch_ok_c ? mem[pc[AW+1:2]] : FILL_INST;
  end

  assign ld.ld_ready    = ld_ready_q;
  assign core_nrst      = core_nrst_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign words_loaded   = waddr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          nrst;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          core_nrst;
  logic          busy;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_loader_if ld_if ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .FILL_INST(FILL)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .pc           (pc),
    .inst         (inst),
    .ld           (ld_if.slave),
    .core_nrst    (core_nrst),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic core_before_last;
  logic [7:0] prog [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, inst, exp);
  endtask

  // Offer one byte (after optional idle gap) until it is handshaken
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int   tries = 0;
    logic acc   = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      ld_if.ld_valid = 1'b0;
      ld_if.ld_data  = 8'hEE;
      ld_if.ld_last  = 1'b1;
    end
    do begin
      @(negedge clk);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = d;
      ld_if.ld_last  = last;
      acc = ld_if.ld_ready;
      if (last) core_before_last = core_nrst;
      @(posedge clk);
      tries++;
    end while (!acc && tries < 50);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  // Send the queued program; with the checksum build a checksum byte is appended
  task automatic send_prog(input int gaps);
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < prog.size(); i++) begin
      sum = 8'(sum + prog[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(prog[i], 1'b0, gaps ? (i % 3) : 0);
`else
      send_byte(prog[i], (i == prog.size() - 1), gaps ? (i % 3) : 0);
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - sum), 1'b1, 0);
`endif
    go_idle();
  endtask

  task automatic restart();
    @(negedge clk);
    ld_if.ld_restart = 1'b1;
    @(negedge clk);
    ld_if.ld_restart = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst             = 1'b0;
    pc               = 32'h0;
    ld_if.ld_valid   = 1'b0;
    ld_if.ld_data    = 8'h00;
    ld_if.ld_last    = 1'b0;
    ld_if.ld_restart = 1'b0;
    core_before_last = 1'bx;

    // Reset state
    #12;
    check("rst_core_nrst", 32'(core_nrst), 32'd0);
    check("rst_ld_ready",  32'(ld_if.ld_ready), 32'd1);
    check("rst_err",       32'(err), 32'd0);
    check("rst_busy",      32'(busy), 32'd1);
    check("rst_words",     32'(words_loaded), 32'd0);
    check_fetch("rst_inst", 32'h0, FILL);
    @(negedge clk);
    nrst = 1'b1;

    // Two-word program
    prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h30, 8'h00};
    send_prog(0);
    check("p1_core_before", 32'(core_before_last), 32'd0);
    check("p1_core_nrst",   32'(core_nrst), 32'd1);
    check("p1_words",       32'(words_loaded), 32'd2);
    check("p1_busy",        32'(busy), 32'd0);
    check("p1_ready",       32'(ld_if.ld_ready), 32'd0);
    check_fetch("p1_inst0", 32'h0, 32'h0010_0013);
    check_fetch("p1_inst4", 32'h4, 32'h0030_0093);
    check_fetch("p1_mis",   32'h2, FILL);

    // Bytes offered in RUN are never accepted
    @(negedge clk);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 8'h55;
    ld_if.ld_last  = 1'b1;
    repeat (4) @(negedge clk);
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    check("run_hold_words", 32'(words_loaded), 32'd2);
    check_fetch("run_hold_inst", 32'h0, 32'h0010_0013);

    // Restart from RUN
    restart();
    check("rs_core_nrst", 32'(core_nrst), 32'd0);
    check("rs_words",     32'(words_loaded), 32'd0);
    check("rs_busy",      32'(busy), 32'd1);
    check_fetch("rs_inst", 32'h0, FILL);

    // Six-byte program, partial final word
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_prog(0);
    check("p2_words", 32'(words_loaded), 32'd2);
    check_fetch("p2_inst0", 32'h0, 32'h4433_2211);
    check_fetch("p2_inst4", 32'h4, 32'h0000_6655);
    check_fetch("p2_mis",   32'h2, FILL);
    check_fetch("p2_oor",   32'(4 * DEPTH), FILL);

    // Byte presented together with restart is discarded; then a gappy stream
    @(negedge clk);
    ld_if.ld_valid   = 1'b1;
    ld_if.ld_data    = 8'hFF;
    ld_if.ld_restart = 1'b1;
    @(negedge clk);
    ld_if.ld_restart = 1'b0;
    ld_if.ld_valid   = 1'b0;
    check("rsd_words", 32'(words_loaded), 32'd0);
    prog = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29};
    send_prog(1);
    check("p3_words", 32'(words_loaded), 32'd3);
    check_fetch("p3_inst0", 32'h0, 32'hD4C3_B2A1);
    check_fetch("p3_inst4", 32'h4, 32'h1807_F6E5);
    check_fetch("p3_inst8", 32'h8, 32'h0000_0029);

    // Overflow: one byte past a full memory
    restart();
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i), 1'b0, 0);
    go_idle();
    check("ov_words_full", 32'(words_loaded), 32'(DEPTH));
    check("ov_err_before", 32'(err), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h5A, 1'b0, 0);
`endif
    send_byte(8'h01, 1'b1, 0);
    go_idle();
    check("ov_err",       32'(err), 32'd1);
    check("ov_core_nrst", 32'(core_nrst), 32'd0);
    check("ov_ready",     32'(ld_if.ld_ready), 32'd0);
    check("ov_busy",      32'(busy), 32'd0);
    check("ov_words",     32'(words_loaded), 32'(DEPTH));
    check_fetch("ov_inst", 32'h0, FILL);
    repeat (3) @(negedge clk);
    check("ov_err_hold", 32'(err), 32'd1);
    restart();
    check("ovr_err",   32'(err), 32'd0);
    check("ovr_words", 32'(words_loaded), 32'd0);
    check("ovr_busy",  32'(busy), 32'd1);
    check("ovr_ready", 32'(ld_if.ld_ready), 32'd1);

    // Reset in the middle of a load
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b0, 0);
    go_idle();
    check("mr_words_pre", 32'(words_loaded), 32'd1);
    nrst = 1'b0;
    #1;
    check("mr_core_nrst", 32'(core_nrst), 32'd0);
    check("mr_words",     32'(words_loaded), 32'd0);
    check("mr_ready",     32'(ld_if.ld_ready), 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    prog = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_prog(0);
    check("mr_core_run", 32'(core_nrst), 32'd1);
    check("mr_words_run", 32'(words_loaded), 32'd1);
    check_fetch("mr_inst", 32'h0, 32'h1234_5678);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    restart();
    send_byte(8'h13, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'hED, 1'b1, 0);
    go_idle();
    check("ck_good_core", 32'(core_nrst), 32'd1);
    check("ck_good_err",  32'(err), 32'd0);
    check_fetch("ck_good_inst", 32'h0, 32'h0000_0013);
    restart();
    send_byte(8'h13, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'hEE, 1'b1, 0);
    go_idle();
    check("ck_bad_err",  32'(err), 32'd1);
    check("ck_bad_core", 32'(core_nrst), 32'd0);
    @(negedge clk);
    check("ck_bad_core_hold", 32'(core_nrst), 32'd0);
    restart();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory with a byte-serial program loader. It sits directly upstream of the processor core.
- The host streams a program in over a valid/ready byte port. The block packs bytes into 32-bit little-endian words and writes them sequentially from word 0.
- After loading, it releases the core from reset and serves the instruction at the core's pc combinationally.
- It owns the core's reset output, so the core never fetches from a partially loaded memory.

Parameters:
- DEPTH, 256, number of 32-bit instruction words.
- AW, 8, word-address width; must satisfy 2^AW >= DEPTH.
- FILL_INST, 32'h0000_0013, instruction returned whenever no valid fetch exists (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- pc  in  32  byte address from the core.
- inst  out  32  instruction for pc.
- ld_valid  in  1  host byte valid.
- ld_data  in  8  host byte.
- ld_last  in  1  marks the final byte of the program; qualified by ld_valid.
- ld_ready  out  1  block accepts a byte this cycle.
- ld_restart  in  1  single-cycle request to abandon run/error and reload.
- core_nrst  out  1  active-low reset to the processor core.
- busy  out  1  high in IDLE and LOAD.
- err  out  1  high in ERROR.
- words_loaded  out  AW+1  count of words written in the current load.

Behaviour:
- Reset (async, nrst=0):
  - State becomes IDLE; byte lane = 0; word address = 0; words_loaded = 0; assembly register = 0.
  - Outputs: core_nrst=0, ld_ready=1, err=0, busy=1.
  - Memory contents are not cleared.
- A byte is accepted on a cycle with ld_valid && ld_ready.
- States and transitions:
  - IDLE: ld_ready=1. An accepted byte stores into lane 0 and moves to LOAD. If that byte has ld_last, it follows the LOAD last-byte rule directly.
  - LOAD: ld_ready=1. An accepted byte goes into lane k at bits [8k+7:8k], then k increments mod 4.
    - On lane 3, the assembled word is written to mem[waddr]; waddr and words_loaded increment in the same edge.
    - On an accepted ld_last byte: if the word is partial, unfilled upper lanes are zero and the word is written. The state then goes to RUN.
    - If a word write would target waddr == DEPTH, the word is dropped and the state goes to ERROR.
  - RUN: ld_ready=0; core_nrst=1 from the first cycle in RUN (registered output, one cycle after the last byte is accepted). busy=0. ld_restart moves to IDLE; core_nrst=0 on the next cycle; waddr, words_loaded and lane are cleared.
  - ERROR: err=1, core_nrst=0, ld_ready=0. The only exits are ld_restart (to IDLE) or nrst.
- ld_restart in IDLE or LOAD also clears the counters and returns to IDLE. Any byte presented in that cycle is discarded.
- Fetch path (combinational):
  - In RUN with pc[1:0]==0 and pc[31:2] < DEPTH: inst = mem[pc[AW+1:2]].
  - Otherwise (misaligned, out of range, or any non-RUN state): inst = FILL_INST.
- Simultaneous memory write and read cannot occur, because writes happen only outside RUN.
- Zero-length program is impossible: a program has at least one byte.
- Reset mid-LOAD leaves partially written memory. A new full load is required before the core runs.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The byte carrying ld_last is a checksum, not program data; it is never written to memory.
  - An 8-bit accumulator sums all preceding accepted bytes mod 256 and clears with the counters.
  - On the checksum byte, any pending partial word is written zero-padded.
  - If (sum + checksum) mod 256 == 0, go to RUN; else go to ERROR.
- Undefined: the ld_last byte is ordinary data, with no accumulator logic and no checksum error path.

Test Plan:
- Reset release, then stream bytes 13 00 10 00 | 93 00 30 00, last on byte 8 → mem[0]=32'h0010_0013, mem[1]=32'h0030_0093, words_loaded=2. core_nrst rises one cycle after the last accept; inst at pc=4 is 32'h0030_0093.
- Six-byte program ending with ld_last → mem[1] upper two bytes are zero. Fetch with pc=2 (misaligned) or pc=4*DEPTH → inst=32'h0000_0013.
- ld_valid held high while ld_ready toggles, plus gaps with ld_valid low → only handshaken bytes are counted; the final memory image matches the sent sequence exactly.
- Stream 4*DEPTH+1 bytes → ERROR after the word-DEPTH write attempt, err=1, core_nrst=0. Then ld_restart → IDLE, words_loaded=0, err=0.
- Assert nrst mid-LOAD (after 5 bytes) → core_nrst=0 and words_loaded=0 immediately. A reload of 4 bytes then reaches RUN with words_loaded=1.
- With IMEM_LOADER_CHECKSUM_EN: bytes 13 00 00 00 plus checksum ED → RUN. The same stream with checksum EE → ERROR, core_nrst stays 0.
